gate_op_arbiter: RTL and testbench

// - Shares one mux-built W-bit bitwise gate unit (AND/OR/NOT/XOR/XNOR/NAND) among NUM_REQ requesters.
// - Round-robin arbitration, one operation in flight, valid/ready handshake on both request and response sides.
// - Sits between software-visible requesters and the mux2-based gate datapath; it is the only path into that unit.

---
 rtl/gate_pkg.sv | 19 +
 rtl/gate_op_arbiter_if.sv | 29 ++
 rtl/mux_gate_unit.sv | 48 ++++
 rtl/gate_op_arbiter.sv | 144 ++++++++++++++
 tb/tb_gate_op_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the gate-op arbiter: opcode encodings and FSM states.
package gate_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd4;
    localparam logic [OP_W-1:0] OP_NAND = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/gate_op_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the gate-op arbiter.
// The master side is the requester/consumer collective; the slave side is the arbiter.
interface gate_op_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int W       = 8,
    parameter int IDW     = 2
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [gate_pkg::OP_W*NUM_REQ-1:0]  req_op;
    logic [W*NUM_REQ-1:0]               req_a;
    logic [W*NUM_REQ-1:0]               req_b;
    logic                               rsp_valid;
    logic                               rsp_ready;
    logic [IDW-1:0]                     rsp_id;
    logic [W-1:0]                       rsp_y;
    logic                               rsp_err;
    logic                               busy;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y, rsp_err, busy
    );
endinterface

// File: rtl/mux_gate_unit.sv
// Bitwise gate unit built purely from 2:1 muxes. Each bit forms all six
// gate results from a/b-steered muxes, then a 3-level op-steered tree picks one.
// Opcodes 6 and 7 select a forced zero and raise err.
module mux2 (
    input  logic d0,
    input  logic d1,
    input  logic s,
    output logic y
);
    assign y = s ? d1 : d0;
endmodule

module mux_gate_unit
    import gate_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [OP_W-1:0] op,
    output logic [W-1:0]    y,
    output logic            err
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        logic nb, f_and, f_or, f_not, f_xor, f_xnor, f_nand;
        logic m01, m23, m45, m0123, m4567;

        // Gate functions, each a mux steered by operand a
        mux2 u_nb   (.d0(1'b1),  .d1(1'b0),  .s(b[i]), .y(nb));
        mux2 u_and  (.d0(1'b0),  .d1(b[i]),  .s(a[i]), .y(f_and));
        mux2 u_or   (.d0(b[i]),  .d1(1'b1),  .s(a[i]), .y(f_or));
        mux2 u_not  (.d0(1'b1),  .d1(1'b0),  .s(a[i]), .y(f_not));
        mux2 u_xor  (.d0(b[i]),  .d1(nb),    .s(a[i]), .y(f_xor));
        mux2 u_xnor (.d0(nb),    .d1(b[i]),  .s(a[i]), .y(f_xnor));
        mux2 u_nand (.d0(1'b1),  .d1(nb),    .s(a[i]), .y(f_nand));

        // Opcode selection tree: op[0], then op[1], then op[2]
        mux2 u_m01   (.d0(f_and),  .d1(f_or),   .s(op[0]), .y(m01));
        mux2 u_m23   (.d0(f_not),  .d1(f_xor),  .s(op[0]), .y(m23));
        mux2 u_m45   (.d0(f_xnor), .d1(f_nand), .s(op[0]), .y(m45));
        mux2 u_m0123 (.d0(m01),    .d1(m23),    .s(op[1]), .y(m0123));
        mux2 u_m4567 (.d0(m45),    .d1(1'b0),   .s(op[1]), .y(m4567));
        mux2 u_y     (.d0(m0123),  .d1(m4567),  .s(op[2]), .y(y[i]));
    end

    // Illegal opcodes are exactly those with op[2] and op[1] both set
    mux2 u_err (.d0(1'b0), .d1(op[1]), .s(op[2]), .y(err));
endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter that feeds one shared mux gate unit. One operation is
// in flight at a time: IDLE grants and latches, EXEC registers the result,
// RESP holds it until the consumer takes it.
module gate_op_arbiter
    import gate_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int W       = 8,
    parameter int IDW     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    gate_op_arbiter_if.slave  bus
);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    y_q, y_d;
    logic            err_q, err_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            busy_q, busy_d;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [W-1:0]    gate_y;
    logic            gate_err;

    // First valid requester at or after ptr, wrapping; MSB flags a hit.
    // Scanning from the farthest slot back lets the nearest hit win.
    function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDW-1:0]     ptr);
        logic [IDW:0]   res;
        logic [IDW-1:0] idx;
        int             pos;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % NUM_REQ;
            idx = pos[IDW-1:0];
            if (valid[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    mux_gate_unit #(.W(W)) u_gate (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .y   (gate_y),
        .err (gate_err)
    );

    // Round-robin winner among the current requests
    always_comb begin
        {grant_found, grant_idx} = rr_pick(bus.req_valid, ptr_q);
    end

    // Accept strobe for the winner, only while idle and out of reset
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && (state_q == S_IDLE) && grant_found) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state and datapath-load decisions
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        y_d         = y_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    id_d    = grant_idx;
                    op_d    = bus.req_op[grant_idx*OP_W +: OP_W];
                    a_d     = bus.req_a[grant_idx*W +: W];
                    b_d     = bus.req_b[grant_idx*W +: W];
                    ptr_d   = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                y_d         = gate_y;
                err_d       = gate_err;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: operand and result registers are reset too, so outputs read as zero after reset and a dropped op leaves nothing stale.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            y_q         <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            y_q         <= y_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_y     = y_q;
    assign bus.rsp_err   = err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_gate_op_arbiter.sv
// Self-checking bench for gate_op_arbiter: directed opcode table, fairness,
// backpressure, async reset mid-op, sparse wrap-around, then random traffic
// against a transaction-level reference model.
module tb_gate_op_arbiter;
    import gate_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int W       = 8;
    localparam int IDW     = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gate_op_arbiter_if #(.NUM_REQ(NUM_REQ), .W(W), .IDW(IDW)) bus ();

    gate_op_arbiter #(.NUM_REQ(NUM_REQ), .W(W), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int         req;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Drive point: just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.req_op[i*3 +: 3] = op;
        bus.req_a[i*8 +: 8]  = a;
        bus.req_b[i*8 +: 8]  = b;
        bus.req_valid[i]     = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_busy"},      bus.busy,      0);
        check({tag, "_rsp_y"},     bus.rsp_y,     0);
        check({tag, "_rsp_id"},    bus.rsp_id,    0);
        check({tag, "_rsp_err"},   bus.rsp_err,   0);
        check({tag, "_req_ready"}, bus.req_ready, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference gate function computed directly from the opcode table
    function automatic logic [8:0] gate_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return {1'b0, a & b};
            3'd1:    return {1'b0, a | b};
            3'd2:    return {1'b0, ~a};
            3'd3:    return {1'b0, a ^ b};
            3'd4:    return {1'b0, ~(a ^ b)};
            3'd5:    return {1'b0, ~(a & b)};
            default: return {1'b1, 8'h00};
        endcase
    endfunction

    // Round-robin rule: first valid requester at ptr, ptr+1, ... wrapping
    function automatic int model_winner(input logic [3:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // One isolated transaction, checking grant, 2-cycle latency and the result
    task automatic single_op(input vec_t v, input string tag);
        bit got = 0;
        set_req(v.req, v.op, v.a, v.b);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req_ready != 0) begin
                got = 1;
                break;
            end
            step();
        end
        check({tag, "_grant"}, bus.req_ready, 32'd1 << v.req);
        if (!got) return;
        step();
        bus.req_valid = '0;
        @(negedge clk);
        check({tag, "_valid_n1"}, bus.rsp_valid, 0);
        step();
        @(negedge clk);
        check({tag, "_valid_n2"}, bus.rsp_valid, 1);
        check({tag, "_id"},  bus.rsp_id,  v.req);
        check({tag, "_y"},   bus.rsp_y,   v.y);
        check({tag, "_err"}, bus.rsp_err, v.err);
        step();
        @(negedge clk);
        check({tag, "_valid_after"}, bus.rsp_valid, 0);
        check({tag, "_busy_after"},  bus.busy,      0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         order[$];
        int         cyc[$];
        int         exp_order[6];
        logic [7:0] hold_y;
        int         m_ptr, m_age, m_gnt, m_id, w;
        bit         m_pending;
        logic [2:0] m_op;
        logic [7:0] m_a, m_b;
        logic [8:0] ref_v;
        logic [3:0] exp_ready;

        vecs[0] = '{0, OP_AND,  8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[1] = '{0, OP_OR,   8'hA5, 8'h0F, 8'hAF, 1'b0};
        vecs[2] = '{1, OP_NOT,  8'hA5, 8'h0F, 8'h5A, 1'b0};
        vecs[3] = '{2, OP_XOR,  8'hA5, 8'h0F, 8'hAA, 1'b0};
        vecs[4] = '{3, OP_XNOR, 8'hA5, 8'h0F, 8'h55, 1'b0};
        vecs[5] = '{0, OP_NAND, 8'hA5, 8'h0F, 8'hFA, 1'b0};
        vecs[6] = '{2, 3'd7,    8'hFF, 8'hFF, 8'h00, 1'b1};
        vecs[7] = '{2, OP_AND,  8'hA5, 8'h0F, 8'h05, 1'b0};
        vecs[8] = '{1, 3'd6,    8'h5A, 8'hC3, 8'h00, 1'b1};
        vecs[9] = '{3, OP_OR,   8'h00, 8'h00, 8'h00, 1'b0};

        // Reset values, observed while reset is held
        rst_n = 1'b0;
        clear_inputs();
        bus.req_valid = 4'b1111;
        #3;
        check_reset_outputs("reset_hold");
        do_reset();
        @(negedge clk);
        check_reset_outputs("reset_released");
        step();

        // Opcode table, including illegal opcodes followed by legal ones
        for (int i = 0; i < 10; i++) begin
            single_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Fairness: all requesters always valid
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, OP_AND, 8'(i), 8'hFF);
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 40 && order.size() < 6; c++) begin
            @(negedge clk);
            if (bus.req_ready != 0) begin
                check("fair_onehot", $countones(bus.req_ready), 1);
                for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) order.push_back(i);
                cyc.push_back(c);
            end
            step();
        end
        exp_order = '{0, 1, 2, 3, 0, 1};
        check("fair_count", order.size(), 6);
        for (int i = 0; i < 6 && i < order.size(); i++) begin
            check($sformatf("fair_order%0d", i), order[i], exp_order[i]);
            if (i > 0) check($sformatf("fair_spacing%0d", i), cyc[i] - cyc[i-1], 3);
        end
        bus.req_valid = '0;
        repeat (4) step();

        // Backpressure: response held while consumer stalls
        do_reset();
        set_req(0, OP_XOR, 8'h3C, 8'h0F);
        set_req(1, OP_OR,  8'h11, 8'h22);
        @(negedge clk);
        check("bp_grant0", bus.req_ready, 4'b0001);
        step();
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        check("bp_exec_busy", bus.busy, 1);
        step();
        @(negedge clk);
        check("bp_rsp_valid", bus.rsp_valid, 1);
        hold_y = bus.rsp_y;
        check("bp_rsp_y", hold_y, 8'h33);
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            check("bp_hold_valid", bus.rsp_valid, 1);
            check("bp_hold_y",     bus.rsp_y,     8'h33);
            check("bp_hold_id",    bus.rsp_id,    0);
            check("bp_hold_err",   bus.rsp_err,   0);
            check("bp_hold_busy",  bus.busy,      1);
            check("bp_hold_ready", bus.req_ready, 0);
        end
        step();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_ready", bus.req_ready, 0);
        step();
        @(negedge clk);
        check("bp_next_grant", bus.req_ready, 4'b0010);
        check("bp_rsp_dropped", bus.rsp_valid, 0);
        step();
        bus.req_valid = '0;
        step();
        @(negedge clk);
        check("bp_second_id", bus.rsp_id, 1);
        check("bp_second_y",  bus.rsp_y,  8'h33);
        repeat (2) step();

        // Async reset in EXEC drops the op; ptr returns to 0
        do_reset();
        set_req(0, OP_OR, 8'h0F, 8'hF0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("rst_grant", bus.req_ready, 4'b0001);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        check("rst_exec_busy", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        step();
        check_reset_outputs("rst_held");
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_no_stale_valid", bus.rsp_valid, 0);
            check("rst_no_stale_busy",  bus.busy,      0);
            step();
        end
        set_req(0, OP_AND, 8'hFF, 8'h0F);
        set_req(3, OP_AND, 8'h00, 8'h00);
        @(negedge clk);
        check("rst_ptr0_grant", bus.req_ready, 4'b0001);
        step();
        bus.req_valid = '0;
        step();
        @(negedge clk);
        check("rst_after_id", bus.rsp_id, 0);
        check("rst_after_y",  bus.rsp_y,  8'h0F);
        repeat (2) step();

        // Sparse and wrap-around
        do_reset();
        bus.rsp_ready = 1'b1;
        set_req(3, OP_NOT, 8'h3C, 8'h00);
        @(negedge clk);
        check("sparse_grant3", bus.req_ready, 4'b1000);
        step();
        bus.req_valid = '0;
        step();
        @(negedge clk);
        check("sparse_id3", bus.rsp_id, 3);
        check("sparse_y3",  bus.rsp_y,  8'hC3);
        step();
        set_req(1, OP_XOR, 8'hFF, 8'h0F);
        @(negedge clk);
        check("sparse_grant1", bus.req_ready, 4'b0010);
        step();
        bus.req_valid = '0;
        step();
        @(negedge clk);
        check("sparse_id1", bus.rsp_id, 1);
        check("sparse_y1",  bus.rsp_y,  8'hF0);
        step();
        set_req(0, OP_AND, 8'h00, 8'h00);
        set_req(2, OP_AND, 8'h00, 8'h00);
        @(negedge clk);
        check("sparse_grant2", bus.req_ready, 4'b0100);
        step();
        bus.req_valid = '0;
        repeat (3) step();

        // Random traffic against the transaction-level model
        do_reset();
        m_ptr = 0; m_pending = 0; m_age = 0; m_gnt = -1; m_id = 0;
        m_op = '0; m_a = '0; m_b = '0;
        for (int it = 0; it < 400; it++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == m_gnt) begin
                    bus.req_valid[i] = ($urandom_range(0, 1) == 1);
                    bus.req_op[i*3 +: 3] = 3'($urandom_range(0, 7));
                    bus.req_a[i*8 +: 8]  = 8'($urandom);
                    bus.req_b[i*8 +: 8]  = 8'($urandom);
                end else if (bus.req_valid[i]) begin
                    if ($urandom_range(0, 9) == 0) bus.req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    set_req(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
                end
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            w = model_winner(bus.req_valid, m_ptr);
            exp_ready = (!m_pending && w >= 0) ? 4'(1 << w) : 4'b0000;
            check("rand_req_ready", bus.req_ready, exp_ready);
            check("rand_busy",      bus.busy,      m_pending);
            check("rand_rsp_valid", bus.rsp_valid, m_pending && m_age == 2);
            if (m_pending && m_age == 2) begin
                ref_v = gate_ref(m_op, m_a, m_b);
                check("rand_rsp_id",  bus.rsp_id,  m_id);
                check("rand_rsp_y",   bus.rsp_y,   ref_v[7:0]);
                check("rand_rsp_err", bus.rsp_err, ref_v[8]);
            end
            @(posedge clk);
            m_gnt = -1;
            if (!m_pending) begin
                if (w >= 0) begin
                    m_id      = w;
                    m_op      = bus.req_op[w*3 +: 3];
                    m_a       = bus.req_a[w*8 +: 8];
                    m_b       = bus.req_b[w*8 +: 8];
                    m_ptr     = (w + 1) % NUM_REQ;
                    m_pending = 1;
                    m_age     = 1;
                    m_gnt     = w;
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (bus.rsp_ready) begin
                m_pending = 0;
            end
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
